// File: rtl/dtw_core_ctrl.sv
// Sequencing controller for the dtw_core_datapath systolic DTW array: job intake, stream gating, pad/flush, result capture.
// Optional DTW_CTRL_PERF_EN adds perf_cycles/perf_stalls counters and ports.
module dtw_core_ctrl #(
  parameter int unsigned       width    = 16,
  parameter int unsigned       SQG_SIZE = 250,
  parameter logic [width-1:0]  PAD_WORD = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       ref_len_in,
  output logic              busy,
  input  logic              sq_valid,
  output logic              sq_ready,
  input  logic [width-1:0]  sq_data,
  input  logic              ref_valid,
  output logic              ref_ready,
  input  logic [width-1:0]  ref_data,
  output logic              res_valid,
  output logic [width-1:0]  res_minval,
  output logic [31:0]       res_position,
  output logic              res_err,
  output logic              dp_rst,
  output logic              dp_running,
  output logic [width-1:0]  dp_squiggle,
  output logic [width-1:0]  dp_rword,
  output logic [31:0]       dp_ref_len,
  input  logic [width-1:0]  dp_minval,
  input  logic [31:0]       dp_position,
  input  logic              dp_done
`ifdef DTW_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_stalls
`endif
);

  localparam int unsigned SQ_W = $clog2(SQG_SIZE + 1);
  localparam int unsigned FL_W = $clog2(SQG_SIZE + 5);
  localparam logic [SQ_W-1:0] SQ_LAST = SQ_W'(SQG_SIZE - 1);
  localparam logic [FL_W-1:0] FL_LAST = FL_W'(SQG_SIZE + 3);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, STREAM, FLUSH, SETTLE, RESULT} state_e;

  state_e            state_q, state_d;
  logic [31:0]       len_q, len_d;
  logic [SQ_W-1:0]   sq_cnt_q, sq_cnt_d;
  logic [31:0]       ref_cnt_q, ref_cnt_d;
  logic              ph_q, ph_d;
  logic [FL_W-1:0]   fl_q, fl_d;
  logic              err_q, err_d;
  logic              dp_rst_q, dp_rst_d;
  logic [width-1:0]  res_minval_q, res_minval_d;
  logic [31:0]       res_position_q, res_position_d;
  logic              res_err_q, res_err_d;
  logic              ref_real;
  logic              fire;

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    sq_cnt_d       = sq_cnt_q;
    ref_cnt_d      = ref_cnt_q;
    ph_d           = ph_q;
    fl_d           = fl_q;
    err_d          = err_q;
    res_minval_d   = res_minval_q;
    res_position_d = res_position_q;
    res_err_d      = res_err_q;
    sq_ready       = 1'b0;
    ref_ready      = 1'b0;
    dp_running     = 1'b0;
    dp_squiggle    = '0;
    dp_rword       = '0;
    fire           = 1'b0;
    ref_real       = (ref_cnt_q < len_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d = ref_len_in;
          err_d = 1'b0;
          ph_d  = 1'b0;
          if (ref_len_in == 32'd0) begin
            state_d        = RESULT;
            res_err_d      = 1'b1;
            res_minval_d   = '1;
            res_position_d = '0;
          end else begin
            state_d = CLEAR;
          end
        end
      end
      CLEAR: begin
        sq_cnt_d  = '0;
        ref_cnt_d = '0;
        fl_d      = '0;
        ph_d      = ~ph_q;
        if (ph_q) state_d = LOAD;
      end
      LOAD: begin
        // Once the reference is exhausted the beat is padded and only the squiggle side gates it.
        dp_squiggle = sq_data;
        dp_rword    = ref_real ? ref_data : PAD_WORD;
        fire        = sq_valid && (ref_real ? ref_valid : 1'b1);
        if (fire) begin
          sq_ready   = 1'b1;
          ref_ready  = ref_real;
          dp_running = 1'b1;
          sq_cnt_d   = sq_cnt_q + 1'b1;
          if (ref_real) ref_cnt_d = ref_cnt_q + 32'd1;
          if (sq_cnt_q == SQ_LAST)
            state_d = (ref_real && ((ref_cnt_q + 32'd1) < len_q)) ? STREAM : FLUSH;
        end
      end
      STREAM: begin
        ref_ready = 1'b1;
        dp_rword  = ref_data;
        fire      = ref_valid;
        if (fire) begin
          dp_running = 1'b1;
          ref_cnt_d  = ref_cnt_q + 32'd1;
          if (ref_cnt_q == (len_q - 32'd1)) state_d = FLUSH;
        end
      end
      FLUSH: begin
        dp_rword = PAD_WORD;
        fl_d     = fl_q + 1'b1;
        if (dp_done) begin
          state_d = SETTLE;
          ph_d    = 1'b0;
        end else begin
          dp_running = 1'b1;
          if (fl_q == FL_LAST) begin
            state_d = SETTLE;
            ph_d    = 1'b0;
            err_d   = 1'b1;
          end
        end
      end
      SETTLE: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          state_d        = RESULT;
          res_minval_d   = dp_minval;
          res_position_d = dp_position;
          res_err_d      = err_q;
        end
      end
      RESULT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    dp_rst_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      len_q          <= '0;
      sq_cnt_q       <= '0;
      ref_cnt_q      <= '0;
      ph_q           <= 1'b0;
      fl_q           <= '0;
      err_q          <= 1'b0;
      dp_rst_q       <= 1'b1;
      res_minval_q   <= '1;
      res_position_q <= '0;
      res_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      sq_cnt_q       <= sq_cnt_d;
      ref_cnt_q      <= ref_cnt_d;
      ph_q           <= ph_d;
      fl_q           <= fl_d;
      err_q          <= err_d;
      dp_rst_q       <= dp_rst_d;
      res_minval_q   <= res_minval_d;
      res_position_q <= res_position_d;
      res_err_q      <= res_err_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign res_valid    = (state_q == RESULT);
  assign res_minval   = res_minval_q;
  assign res_position = res_position_q;
  assign res_err      = res_err_q;
  assign dp_rst       = dp_rst_q;
  assign dp_ref_len   = len_q;

`ifdef DTW_CTRL_PERF_EN
  logic [31:0] cyc_q, cyc_d, stall_q, stall_d;
  logic [31:0] perf_cycles_q, perf_cycles_d, perf_stalls_q, perf_stalls_d;

  always_comb begin
    cyc_d         = cyc_q;
    stall_d       = stall_q;
    perf_cycles_d = perf_cycles_q;
    perf_stalls_d = perf_stalls_q;
    if (state_q == IDLE && state_d == CLEAR) begin
      cyc_d         = '0;
      stall_d       = '0;
      perf_cycles_d = '0;
      perf_stalls_d = '0;
    end else begin
      if (state_q inside {CLEAR, LOAD, STREAM, FLUSH, SETTLE}) cyc_d = cyc_q + 32'd1;
      if ((state_q == LOAD || state_q == STREAM) && !fire) stall_d = stall_q + 32'd1;
      if (state_q == SETTLE && state_d == RESULT) begin
        perf_cycles_d = cyc_q + 32'd1;
        perf_stalls_d = stall_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q         <= '0;
      stall_q       <= '0;
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      cyc_q         <= cyc_d;
      stall_q       <= stall_d;
      perf_cycles_q <= perf_cycles_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_dtw_core_ctrl.sv
// Directed bench for dtw_core_ctrl with SQG_SIZE=4 and a behavioural subsequence-DTW datapath stand-in.
module tb_dtw_core_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] ref_len_in;
  logic        busy;
  logic        sq_valid, sq_ready;
  logic [15:0] sq_data;
  logic        ref_valid, ref_ready;
  logic [15:0] ref_data;
  logic        res_valid;
  logic [15:0] res_minval;
  logic [31:0] res_position;
  logic        res_err;
  logic        dp_rst, dp_running;
  logic [15:0] dp_squiggle, dp_rword;
  logic [31:0] dp_ref_len;
  logic [15:0] dp_minval;
  logic [31:0] dp_position;
  logic        dp_done;
`ifdef DTW_CTRL_PERF_EN
  logic [31:0] perf_cycles, perf_stalls;
  logic [31:0] perf_seen;
`endif

  always #5 clk = ~clk;

  dtw_core_ctrl #(.width(16), .SQG_SIZE(4), .PAD_WORD(16'hFFFF)) dut (
    .clk(clk), .rst(rst), .start(start), .ref_len_in(ref_len_in), .busy(busy),
    .sq_valid(sq_valid), .sq_ready(sq_ready), .sq_data(sq_data),
    .ref_valid(ref_valid), .ref_ready(ref_ready), .ref_data(ref_data),
    .res_valid(res_valid), .res_minval(res_minval), .res_position(res_position), .res_err(res_err),
    .dp_rst(dp_rst), .dp_running(dp_running), .dp_squiggle(dp_squiggle), .dp_rword(dp_rword),
    .dp_ref_len(dp_ref_len), .dp_minval(dp_minval), .dp_position(dp_position), .dp_done(dp_done)
`ifdef DTW_CTRL_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
  );

  // Datapath stand-in: captures the first 4 squiggle words and ref_len reference words,
  // raises done after ref_len+4 running beats, then evaluates subsequence DTW.
  logic [15:0] cap_sq [4];
  logic [15:0] cap_ref [8];
  logic [31:0] run_n;
  logic        done_en;

  function automatic logic [47:0] dtw_eval(input logic [31:0] len);
    int unsigned prev [8];
    int unsigned cur [8];
    int unsigned n, c, m, best, bpos, a, b;
    logic [31:0] bv;
    n = (len > 8) ? 8 : len;
    for (int i = 0; i < 8; i++) begin prev[i] = 0; cur[i] = 0; end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 8; j++) begin
        if (j < int'(n)) begin
          a = cap_sq[i]; b = cap_ref[j];
          c = (a > b) ? a - b : b - a;
          if (i == 0) cur[j] = c;
          else if (j == 0) cur[j] = prev[0] + c;
          else begin
            m = prev[j];
            if (cur[j-1] < m) m = cur[j-1];
            if (prev[j-1] < m) m = prev[j-1];
            cur[j] = c + m;
          end
        end
      end
      prev = cur;
    end
    best = 32'hFFFF_FFFF; bpos = 0;
    for (int j = 0; j < 8; j++)
      if (j < int'(n) && prev[j] < best) begin best = prev[j]; bpos = j; end
    if (best > 32'h0000_FFFF) best = 32'h0000_FFFF;
    bv = best;
    return {bv[15:0], bpos};
  endfunction

  assign dp_done = done_en && (run_n == dp_ref_len + 32'd4);

  always @(posedge clk) begin
    if (dp_rst) begin
      run_n       <= '0;
      dp_minval   <= '1;
      dp_position <= '0;
    end else begin
      if (dp_running) begin
        if (run_n < 32'd4) cap_sq[run_n[1:0]] <= dp_squiggle;
        if (run_n < 32'd8 && run_n < dp_ref_len) cap_ref[run_n[2:0]] <= dp_rword;
        run_n <= run_n + 32'd1;
      end
      if (dp_done) {dp_minval, dp_position} <= dtw_eval(dp_ref_len);
    end
  end

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Handshake monitor; si/ri/cur_len are owned by the stimulus process.
  int unsigned si, ri, cur_len, stall_exp;
  int unsigned mon_run = 0, mon_rr = 0, mon_viol = 0;
  always @(negedge clk) begin
    if (dp_running) mon_run++;
    if (ref_ready) mon_rr++;
    if ((si < 4 || ri < cur_len) &&
        (dp_running !== ((sq_valid && sq_ready) || (ref_valid && ref_ready)))) mon_viol++;
  end

  logic [15:0] sq_vec [4];
  logic [15:0] ref_vec [8];

  task automatic run_job(input int unsigned len, input int unsigned pct, input int unsigned abort_at,
                         output int unsigned res_at, output logic got, output logic [15:0] mv,
                         output logic [31:0] pos, output logic er);
    int unsigned iter;
    logic sf, rf;
    si = 0; ri = 0; cur_len = len; stall_exp = 0;
    got = 1'b0; res_at = 0; mv = '0; pos = '0; er = 1'b0;
    ref_len_in = len; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    iter = 0;
    while (!got && iter < 300 && !(abort_at != 0 && iter == abort_at)) begin
      sq_valid  = (si < 4)   && ($urandom_range(99) >= pct);
      ref_valid = (ri < len) && ($urandom_range(99) >= pct);
      sq_data   = sq_valid  ? sq_vec[si[1:0]]  : '0;
      ref_data  = ref_valid ? ref_vec[ri[2:0]] : '0;
      @(negedge clk);
      sf = sq_valid && sq_ready;
      rf = ref_valid && ref_ready;
      if (iter >= 2 && (si < 4 || ri < len) && !sf && !rf) stall_exp++;
      if (res_valid) begin
        got = 1'b1; res_at = iter + 1; mv = res_minval; pos = res_position; er = res_err;
`ifdef DTW_CTRL_PERF_EN
        perf_seen = perf_stalls;
`endif
      end
      @(posedge clk); #1;
      if (sf) si++;
      if (rf) ri++;
      iter++;
    end
    sq_valid = 1'b0; ref_valid = 1'b0; sq_data = '0; ref_data = '0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned at, r0, rr0;
    logic g, e;
    logic [15:0] mv;
    logic [31:0] pos;

    rst = 1'b0; start = 1'b0; ref_len_in = '0; done_en = 1'b1;
    sq_valid = 1'b0; ref_valid = 1'b0; sq_data = '0; ref_data = '0;
    si = 0; ri = 0; cur_len = 0; stall_exp = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_sq_ready", sq_ready, 0);
    chk("rst_ref_ready", ref_ready, 0);
    chk("rst_dp_running", dp_running, 0);
    chk("rst_dp_rst", dp_rst, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_err", res_err, 0);
    chk("rst_res_minval", res_minval, 32'h0000_FFFF);
    chk("rst_res_position", res_position, 0);
    chk("rst_dp_rword", dp_rword, 0);
    chk("rst_dp_squiggle", dp_squiggle, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rel_dp_rst", dp_rst, 0);

    // Job A: len 8, no stalls; match ends at reference index 5 with zero cost.
    sq_vec  = '{16'd1, 16'd2, 16'd3, 16'd4};
    ref_vec = '{16'd9, 16'd9, 16'd1, 16'd2, 16'd3, 16'd4, 16'd9, 16'd9};
    r0 = mon_run;
    run_job(8, 0, 0, at, g, mv, pos, e);
    chk("A_got", g, 1);
    chk("A_latency", at, 18);
    chk("A_minval", mv, 0);
    chk("A_position", pos, 5);
    chk("A_err", e, 0);
    chk("A_running_beats", mon_run - r0, 12);
    chk("A_pulse_one_cycle", res_valid, 0);
    chk("A_idle_busy", busy, 0);
    chk("A_hold_position", res_position, 5);

    // Job B: same job with ~30% valid drop on both streams.
    run_job(8, 30, 0, at, g, mv, pos, e);
    chk("B_got", g, 1);
    chk("B_minval", mv, 0);
    chk("B_position", pos, 5);
    chk("B_err", e, 0);
`ifdef DTW_CTRL_PERF_EN
    chk("B_perf_stalls", perf_seen, stall_exp);
`endif

    // Job C: len 2 < SQG_SIZE; two real reference words then padding, no STREAM.
    ref_vec = '{16'd3, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    r0 = mon_run; rr0 = mon_rr;
    run_job(2, 0, 0, at, g, mv, pos, e);
    chk("C_got", g, 1);
    chk("C_latency", at, 12);
    chk("C_ref_ready_pulses", mon_rr - rr0, 2);
    chk("C_running_beats", mon_run - r0, 6);
    chk("C_minval", mv, 3);
    chk("C_position", pos, 1);
    chk("C_err", e, 0);

    // Job D: zero-length reference is rejected straight to RESULT.
    r0 = mon_run;
    run_job(0, 0, 0, at, g, mv, pos, e);
    chk("D_got", g, 1);
    chk("D_latency", at, 1);
    chk("D_err", e, 1);
    chk("D_minval", mv, 32'h0000_FFFF);
    chk("D_position", pos, 0);
    chk("D_no_running", mon_run - r0, 0);

    // Job E: datapath never signals done; watchdog ends FLUSH after 8 cycles.
    done_en = 1'b0;
    run_job(2, 0, 0, at, g, mv, pos, e);
    done_en = 1'b1;
    chk("E_got", g, 1);
    chk("E_latency", at, 17);
    chk("E_err", e, 1);

    // Job F: reset asserted mid-STREAM, then a clean job.
    ref_vec = '{16'd9, 16'd9, 16'd1, 16'd2, 16'd3, 16'd4, 16'd9, 16'd9};
    run_job(8, 0, 8, at, g, mv, pos, e);
    chk("F_busy_before", busy, 1);
    chk("F_stream_ref_ready", ref_ready, 1);
    rst = 1'b0;
    #1;
    chk("F_rst_busy", busy, 0);
    chk("F_rst_running", dp_running, 0);
    chk("F_rst_dp_rst", dp_rst, 1);
    chk("F_rst_ref_ready", ref_ready, 0);
    chk("F_rst_res_err", res_err, 0);
    @(posedge clk); #1;
    chk("F_rst_dp_rst_held", dp_rst, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    run_job(8, 0, 0, at, g, mv, pos, e);
    chk("F_got", g, 1);
    chk("F_latency", at, 18);
    chk("F_minval", mv, 0);
    chk("F_position", pos, 5);
    chk("F_err", e, 0);

    chk("running_without_fire", mon_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
